disp_scan_mux: RTL and testbench



---
 rtl/disp_pkg.sv | 28 ++
 rtl/disp_scan_mux_if.sv | 34 +++
 rtl/disp_scan_mux_tick_gen.sv | 42 ++++
 rtl/disp_scan_mux.sv | 142 ++++++++++++++
 tb/tb_disp_scan_mux.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared constants, scan-state encoding and a counter-width
//                helper for the four-digit display scanner.
//  Contents    : ANODE_OFF, DIGIT_BLANK, DP_OFF, scan_state_t, cnt_width()
//  Revision    : 1.0  initial release
// ============================================================================
package disp_pkg;

   localparam logic [3:0] ANODE_OFF   = 4'b1111;   // all anodes disabled
   localparam logic [3:0] DIGIT_BLANK = 4'hF;      // decoder blanks this code
   localparam logic       DP_OFF      = 1'b1;      // decimal point dark

   // Scan state encoding: GUARD = 0, DRIVE = 1. Literals carry an ST_ prefix
   // so they never collide with the GUARD timing parameter of the top.
   typedef enum logic [0:0] {
      ST_GUARD = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_t;

   // Counter width for a divisor; never below one bit.
   function automatic int cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/disp_scan_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scan_mux_if
//  Description : Bundle between the display scanner and its environment.
//  Signals     : digits[15:0]   four BCD nibbles, [3:0] = rightmost digit
//                blink_en[3:0]  per-digit blink request
//                dp_in[3:0]     per-digit decimal point request (active-high)
//                an[3:0]        anode enables, active-low
//                digit_out[3:0] nibble to the segment decoder, F = blank
//                dp_out         decimal point, active-low
//  Modports    : master (source of digits, sink of display), slave (scanner)
//  Revision    : 1.0  initial release
// ============================================================================
interface disp_scan_mux_if;

   logic [15:0] digits;
   logic [3:0]  blink_en;
   logic [3:0]  dp_in;
   logic [3:0]  an;
   logic [3:0]  digit_out;
   logic        dp_out;

   modport master (
      output digits, blink_en, dp_in,
      input  an, digit_out, dp_out
   );

   modport slave (
      input  digits, blink_en, dp_in,
      output an, digit_out, dp_out
   );

endinterface
`default_nettype wire

// File: rtl/disp_scan_mux_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Terminal-count counter, 0..DIV-1 then wraps to 0.
//  Ports       : clk      system clock
//                rst_n    asynchronous active-low reset
//                o_tick   high during the terminal-count cycle, i.e. the
//                         counter wraps on the edge that ends this cycle
//                o_count  current count
//  Revision    : 1.0  initial release
// ============================================================================
module tick_gen
   import disp_pkg::*;
#(
   parameter int DIV = 8,
   parameter int W   = cnt_width(DIV)
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   output logic              o_tick,
   output logic [W-1:0]      o_count
);

   localparam logic [W-1:0] c_TERM = W'(DIV - 1);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (r_count == c_TERM) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_tick  = (r_count == c_TERM);
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/disp_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scan_mux
//  Description : Time-multiplexes a 4-digit BCD value onto a shared-cathode
//                seven-segment display with a blank guard interval at the
//                start of every digit slot, per-digit blink and decimal
//                points. Value and masks are latched once per frame.
//  Ports       : clk     system clock
//                rst_n   asynchronous active-low reset
//                bus     disp_scan_mux_if.slave (digits/blink_en/dp_in in,
//                        an/digit_out/dp_out out, all outputs registered)
//  Revision    : 1.0  initial release
// ============================================================================
module disp_scan_mux
   import disp_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 16,
   parameter int BLINK_DIV   = 25000000
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   disp_scan_mux_if.slave  bus
);

   localparam int              SLOT_W       = cnt_width(REFRESH_DIV);
   localparam logic [SLOT_W-1:0] c_GUARD_LAST = SLOT_W'(GUARD - 1);

   // ---------------------------------------------------------------------
   // Timebases
   // ---------------------------------------------------------------------
   logic              w_slot_tick;
   logic [SLOT_W-1:0] w_slot_cnt;
   logic              w_blink_tick;

   tick_gen #(.DIV(REFRESH_DIV)) u_slot_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .o_tick  (w_slot_tick),
      .o_count (w_slot_cnt)
   );

   tick_gen #(.DIV(BLINK_DIV)) u_blink_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .o_tick  (w_blink_tick),
      .o_count ()
   );

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   scan_state_t r_state;
   logic [1:0]  r_idx;
   logic [15:0] r_shadow;
   logic [3:0]  r_blink_mask;
   logic [3:0]  r_dp_mask;
   logic        r_load_pending;
   logic        r_blink_phase;
   logic [3:0]  r_an;
   logic [3:0]  r_digit;
   logic        r_dp;

   // Next-state values. The output registers are loaded from these so that
   // an/digit_out/dp_out always describe the same cycle as the counters.
   scan_state_t w_state_nxt;
   logic [1:0]  w_idx_nxt;
   logic        w_load;
   logic [15:0] w_shadow_nxt;
   logic [3:0]  w_blink_nxt;
   logic [3:0]  w_dp_nxt;
   logic        w_phase_nxt;
   logic        w_blanked;
   logic [3:0]  w_an_nxt;
   logic [3:0]  w_digit_nxt;
   logic        w_dp_out_nxt;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;

      // The slot wrap ends DRIVE; the last guard count starts DRIVE.
      if (w_slot_tick) begin
         w_state_nxt = ST_GUARD;
         w_idx_nxt   = r_idx + 2'd1;
      end else if (r_state == ST_GUARD && w_slot_cnt == c_GUARD_LAST) begin
         w_state_nxt = ST_DRIVE;
      end

      // New frame content only at power-up and on the digit 3 -> 0 wrap.
      w_load       = r_load_pending || (w_slot_tick && r_idx == 2'd3);
      w_shadow_nxt = w_load ? bus.digits   : r_shadow;
      w_blink_nxt  = w_load ? bus.blink_en : r_blink_mask;
      w_dp_nxt     = w_load ? bus.dp_in    : r_dp_mask;

      w_phase_nxt  = w_blink_tick ? ~r_blink_phase : r_blink_phase;

      w_blanked    = (w_state_nxt == ST_GUARD) ||
                     (w_blink_nxt[w_idx_nxt] && w_phase_nxt);

      w_an_nxt     = ANODE_OFF;
      w_digit_nxt  = DIGIT_BLANK;
      w_dp_out_nxt = DP_OFF;
      if (!w_blanked) begin
         w_an_nxt     = ~(4'b0001 << w_idx_nxt);
         w_digit_nxt  = w_shadow_nxt[{w_idx_nxt, 2'b00} +: 4];
         w_dp_out_nxt = ~w_dp_nxt[w_idx_nxt];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_GUARD;
         r_idx          <= 2'd0;
         r_shadow       <= 16'hFFFF;
         r_blink_mask   <= 4'b0000;
         r_dp_mask      <= 4'b0000;
         r_load_pending <= 1'b1;
         r_blink_phase  <= 1'b0;
         r_an           <= ANODE_OFF;
         r_digit        <= DIGIT_BLANK;
         r_dp           <= DP_OFF;
      end else begin
         r_state        <= w_state_nxt;
         r_idx          <= w_idx_nxt;
         r_shadow       <= w_shadow_nxt;
         r_blink_mask   <= w_blink_nxt;
         r_dp_mask      <= w_dp_nxt;
         r_load_pending <= 1'b0;
         r_blink_phase  <= w_phase_nxt;
         r_an           <= w_an_nxt;
         r_digit        <= w_digit_nxt;
         r_dp           <= w_dp_out_nxt;
      end
   end

   assign bus.an        = r_an;
   assign bus.digit_out = r_digit;
   assign bus.dp_out    = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_scan_mux
//  Description : Self-checking bench for disp_scan_mux (REFRESH_DIV=8,
//                GUARD=2, BLINK_DIV=64). A cycle-indexed model predicts the
//                display from elapsed clocks since reset release; directed
//                literal checks pin specific points of the scan.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_disp_scan_mux;

   localparam int RD    = 8;
   localparam int G     = 2;
   localparam int BD    = 64;
   localparam int FRAME = 4 * RD;

   logic clk = 1'b0;
   logic rst_n;

   disp_scan_mux_if bus ();

   disp_scan_mux #(
      .REFRESH_DIV (RD),
      .GUARD       (G),
      .BLINK_DIV   (BD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------------------------------------------------------------
   // Model: m_t = clock edges since reset release. Frame content is taken
   // at edge 1 and every FRAME edges afterwards.
   // ---------------------------------------------------------------------
   int          m_t = 0;
   logic [15:0] m_dig = 16'hFFFF;
   logic [3:0]  m_blk = 4'b0000;
   logic [3:0]  m_dp  = 4'b0000;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_t <= 0;
      end else begin
         m_t <= m_t + 1;
         if (m_t + 1 == 1 || (m_t + 1) % FRAME == 0) begin
            m_dig <= bus.digits;
            m_blk <= bus.blink_en;
            m_dp  <= bus.dp_in;
         end
      end
   end

   function automatic logic [8:0] model_out(input int t);
      int         s;
      int         idx;
      int         ph;
      logic [3:0] one;
      s   = t % RD;
      idx = (t / RD) % 4;
      ph  = (t / BD) % 2;
      one = 4'b0001;
      if (t == 0 || s < G || (m_blk[idx] && ph == 1))
         return {4'b1111, 4'hF, 1'b1};
      return {~(one << idx), m_dig[idx*4 +: 4], ~m_dp[idx]};
   endfunction

   task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0d: got an=%b digit=%h dp=%b, want an=%b digit=%h dp=%b",
                  name, m_t, got[8:5], got[4:1], got[0], exp[8:5], exp[4:1], exp[0]);
      end
   endtask

   // Per-cycle model comparison plus the structural invariant.
   always @(negedge clk) begin
      logic ok;
      chk("model", {bus.an, bus.digit_out, bus.dp_out}, model_out(m_t));
      ok = ($countones(~bus.an) <= 1) && ((m_t % RD) >= G || bus.an == 4'b1111);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL invariant t=%0d: an=%b", m_t, bus.an);
      end
   end

   task automatic at_t(input int n);
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (m_t == n) return;
      end
      total++;
      bad++;
      $display("FAIL timeout waiting for t=%0d, at t=%0d", n, m_t);
   endtask

   task automatic lit(input string name, input logic [3:0] an, input logic [3:0] d, input logic dp);
      chk(name, {bus.an, bus.digit_out, bus.dp_out}, {an, d, dp});
   endtask

   logic [15:0] dtab [4] = '{16'h9012, 16'h3456, 16'h0A7F, 16'h4321};

   initial begin
      rst_n        = 1'b0;
      bus.digits   = 16'h1234;
      bus.blink_en = 4'b0000;
      bus.dp_in    = 4'b0000;

      // 1. Reset and first frame
      repeat (3) @(negedge clk);
      lit("reset", 4'b1111, 4'hF, 1'b1);
      rst_n = 1'b1;
      at_t(1);  lit("t1_guard",  4'b1111, 4'hF, 1'b1);
      at_t(2);  lit("d0_first",  4'b1110, 4'h4, 1'b1);
      at_t(7);  lit("d0_last",   4'b1110, 4'h4, 1'b1);
      at_t(8);  lit("d1_guard",  4'b1111, 4'hF, 1'b1);
      at_t(10); lit("d1_drive",  4'b1101, 4'h3, 1'b1);

      // 2. Anti-tear: change while digit 1 is on
      at_t(12); bus.digits = 16'h5678;
      at_t(18); lit("tear_d2",   4'b1011, 4'h2, 1'b1);
      at_t(26); lit("tear_d3",   4'b0111, 4'h1, 1'b1);
      at_t(34); lit("new_d0",    4'b1110, 4'h8, 1'b1);
      at_t(42); lit("new_d1",    4'b1101, 4'h7, 1'b1);
      at_t(50); lit("new_d2",    4'b1011, 4'h6, 1'b1);
      at_t(58); lit("new_d3",    4'b0111, 4'h5, 1'b1);

      // 3. Blink digit 0
      at_t(60);  bus.blink_en = 4'b0001;
      at_t(66);  lit("blink_off",  4'b1111, 4'hF, 1'b1);
      at_t(74);  lit("blink_d1",   4'b1101, 4'h7, 1'b1);
      at_t(130); lit("blink_on",   4'b1110, 4'h8, 1'b1);
      at_t(194); lit("blink_off2", 4'b1111, 4'hF, 1'b1);

      // 4. Decimal point on digit 2
      at_t(196); bus.blink_en = 4'b0000; bus.dp_in = 4'b0100;
      at_t(240); lit("dp_guard",  4'b1111, 4'hF, 1'b1);
      at_t(242); lit("dp_d2",     4'b1011, 4'h6, 1'b0);
      at_t(250); lit("dp_d3",     4'b0111, 4'h5, 1'b1);

      // 5. Asynchronous reset at slot 5 of digit 2
      at_t(277);
      #1 rst_n = 1'b0;
      #1 lit("async_rst", 4'b1111, 4'hF, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      at_t(1);  lit("rst2_guard", 4'b1111, 4'hF, 1'b1);
      at_t(2);  lit("rst2_d0",    4'b1110, 4'h8, 1'b1);

      // 6. Ten frames with changing content; invariants checked every cycle
      for (int f = 0; f < 10; f++) begin
         at_t(40 + f * FRAME + 12);
         bus.digits   = dtab[f % 4];
         bus.blink_en = 4'(f);
         bus.dp_in    = 4'(15 - f);
      end
      at_t(40 + 10 * FRAME + 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
